// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_port_arbiter
//  Description : Shares the core's single memory port between instruction
//                fetch and load/store. One requester is granted at a time.
//                Its request is latched into the mem_* registers, and a
//                request/acknowledge transaction runs on the memory port.
//                A burst limit keeps a waiting fetch from starving. A watchdog
//                aborts transactions that are never acknowledged.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n                 clock (rising edge), async active-low reset
//    instr_request/address      fetch request side (held until instr_ready)
//    instr_ready/valid/rdata    fetch grant pulse, completion pulse, read data
//    data_request/write/address/wdata/size
//                               load/store request side (held until data_ready)
//    data_ready/valid/rdata     load/store grant pulse, completion pulse, data
//    mem_request/write/address/wdata/size
//                               registered memory transaction outputs
//    mem_acknowledge/rdata      memory completion and read data
//    bus_error                  watchdog abort pulse, coincident with valid
// ============================================================================
module memory_port_arbiter #(
  parameter int DATA_BURST_LIMIT = 4,
  parameter int TIMEOUT_CYCLES   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_request,
  input  logic [31:0] instr_address,
  output logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr_rdata,
  input  logic        data_request,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_wdata,
  input  logic [1:0]  data_size,
  output logic        data_ready,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        mem_request,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_acknowledge,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);

  localparam int BURST_W_MIN = $clog2(DATA_BURST_LIMIT + 1);
  localparam int BURST_W     = (BURST_W_MIN > 3) ? BURST_W_MIN : 3;
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(DATA_BURST_LIMIT);
  localparam logic [BURST_W-1:0] BURST_MAX   = '1;
  // The abort fires on the busy cycle in which the count would reach the
  // limit. mem_request is therefore high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_BUSY_INSTR = 2'd1;
  localparam logic [1:0] ST_BUSY_DATA  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [7:0]         wd_q, wd_d;
  logic               mem_request_q, mem_request_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        mem_address_q, mem_address_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [1:0]         mem_size_q, mem_size_d;
  logic               instr_valid_q, instr_valid_d;
  logic               data_valid_q, data_valid_d;
  logic               bus_error_q, bus_error_d;
  logic [31:0]        instr_rdata_q, instr_rdata_d;
  logic [31:0]        data_rdata_q, data_rdata_d;

  logic w_idle;
  logic w_busy;
  logic w_fetch_priority;
  logic w_grant_data;
  logic w_grant_instr;
  logic w_ack_hit;
  logic w_timeout_hit;

  // Grant decision: data wins unless a pending fetch has waited out a full
  // data burst.
  assign w_idle           = (state_q == ST_IDLE);
  assign w_busy           = (state_q == ST_BUSY_INSTR) || (state_q == ST_BUSY_DATA);
  assign w_fetch_priority = instr_request && (burst_q == BURST_LIMIT);
  assign w_grant_data     = w_idle && data_request && !w_fetch_priority;
  assign w_grant_instr    = w_idle && instr_request && !w_grant_data;
  // An acknowledge takes precedence over a watchdog expiry in the same cycle.
  assign w_ack_hit        = w_busy && mem_acknowledge;
  assign w_timeout_hit    = w_busy && !mem_acknowledge && (wd_q == WD_LAST);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_grant_data) begin
          state_d = ST_BUSY_DATA;
        end else if (w_grant_instr) begin
          state_d = ST_BUSY_INSTR;
        end
      end
      ST_BUSY_INSTR, ST_BUSY_DATA: begin
        if (w_ack_hit || w_timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (grant pulses are combinational in IDLE)
  // --------------------------------------------------------------------------
  always_comb begin
    instr_ready = w_grant_instr;
    data_ready  = w_grant_data;
  end

  // --------------------------------------------------------------------------
  // Datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    burst_d       = burst_q;
    wd_d          = wd_q;
    mem_request_d = mem_request_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_size_d    = mem_size_q;
    instr_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    bus_error_d   = 1'b0;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;

    if (w_grant_data) begin
      mem_request_d = 1'b1;
      mem_write_d   = data_write;
      mem_address_d = data_address;
      mem_wdata_d   = data_wdata;
      mem_size_d    = data_size;
      wd_d          = 8'd0;
      // Count consecutive data grants only while a fetch is kept waiting.
      if (instr_request) begin
        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
      end else begin
        burst_d = '0;
      end
    end else if (w_grant_instr) begin
      mem_request_d = 1'b1;
      mem_write_d   = 1'b0;
      mem_address_d = instr_address;
      mem_wdata_d   = 32'h0;
      mem_size_d    = 2'b10;
      wd_d          = 8'd0;
      burst_d       = '0;
    end

    if (w_ack_hit) begin
      mem_request_d = 1'b0;
      if (state_q == ST_BUSY_INSTR) begin
        instr_valid_d = 1'b1;
        instr_rdata_d = mem_rdata;
      end else begin
        data_valid_d = 1'b1;
        // Stores leave the last load result in place.
        if (!mem_write_q) begin
          data_rdata_d = mem_rdata;
        end
      end
    end else if (w_timeout_hit) begin
      mem_request_d = 1'b0;
      bus_error_d   = 1'b1;
      if (state_q == ST_BUSY_INSTR) begin
        instr_valid_d = 1'b1;
        instr_rdata_d = 32'h0;
      end else begin
        data_valid_d = 1'b1;
        if (!mem_write_q) begin
          data_rdata_d = 32'h0;
        end
      end
    end else if (w_busy) begin
      wd_d = wd_q + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q       <= '0;
      wd_q          <= 8'd0;
      mem_request_q <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'h0;
      mem_wdata_q   <= 32'h0;
      mem_size_q    <= 2'b00;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      bus_error_q   <= 1'b0;
      instr_rdata_q <= 32'h0;
      data_rdata_q  <= 32'h0;
    end else begin
      burst_q       <= burst_d;
      wd_q          <= wd_d;
      mem_request_q <= mem_request_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_size_q    <= mem_size_d;
      instr_valid_q <= instr_valid_d;
      data_valid_q  <= data_valid_d;
      bus_error_q   <= bus_error_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign mem_request = mem_request_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_size    = mem_size_q;
  assign instr_valid = instr_valid_q;
  assign data_valid  = data_valid_q;
  assign bus_error   = bus_error_q;
  assign instr_rdata = instr_rdata_q;
  assign data_rdata  = data_rdata_q;

endmodule
`default_nettype wire

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Sequential arbiter that shares the core's single memory port between instruction fetch and load/store accesses. It sits between the fetch stage and the memory stage on one side and the unified memory on the other. It grants one requester at a time, latches the request, and runs a request/acknowledge transaction on the memory port. It also enforces a starvation guard for fetch and a watchdog timeout on unanswered transactions.

## Interface
- DATA_BURST_LIMIT, 4: maximum consecutive data grants while a fetch is pending.
- TIMEOUT_CYCLES, 15: busy cycles without acknowledge before abort; range 1..255.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_request  in  1  fetch request, held until instr_ready.
- instr_address  in  32  fetch address.
- instr_ready  out  1  grant/accept pulse to fetch.
- instr_valid  out  1  one-cycle fetch completion pulse.
- instr_rdata  out  32  fetched word, held until next fetch completion.
- data_request  in  1  load/store request, held until data_ready.
- data_write  in  1  1 = store, 0 = load.
- data_address  in  32  load/store address.
- data_wdata  in  32  store data.
- data_size  in  2  00 byte, 01 half, 10 word.
- data_ready  out  1  grant/accept pulse to load/store.
- data_valid  out  1  one-cycle load/store completion pulse.
- data_rdata  out  32  load data, held until next load completion.
- mem_request  out  1  memory transaction request.
- mem_write  out  1  store transaction.
- mem_address  out  32  latched address.
- mem_wdata  out  32  latched store data.
- mem_size  out  2  latched size; 2'b10 for fetches.
- mem_acknowledge  in  1  transaction complete; mem_rdata valid this cycle.
- mem_rdata  in  32  read data.
- bus_error  out  1  one-cycle pulse on watchdog abort, coincident with the requester's valid.

## Operation
- FSM states: IDLE, BUSY_INSTR, BUSY_DATA.
- IDLE grant decision is combinational; at most one of instr_ready/data_ready is high.
  - data wins, unless instr_request=1 and burst_count == DATA_BURST_LIMIT, in which case fetch wins.
- Grant edge: the requester's address, data, size and write fields are latched into mem_* registers; state moves to BUSY_INSTR or BUSY_DATA.
- burst_count (3-bit min, saturating):
  - +1 on each data grant while instr_request=1.
  - cleared on any fetch grant, or on a data grant with instr_request=0.
- BUSY_x: mem_request=1. On the mem_acknowledge cycle:
  - mem_rdata is captured into instr_rdata (fetch) or data_rdata (load only).
  - Stores leave data_rdata unchanged.
  - Next cycle, x_valid=1 and state=IDLE.
- Watchdog counter:
  - cleared on grant; +1 per BUSY cycle without acknowledge.
  - When it reaches TIMEOUT_CYCLES: abort, drop mem_request, pulse x_valid and bus_error, and load x_rdata with 32'h0 (loads/fetches only).
- mem_acknowledge while in IDLE is ignored.
- Requests that drop before ready are simply not granted; no state is kept.

## Timing
- Reset (async, immediate) values:
  - all outputs 0: mem_request=0, ready=0, valid=0, bus_error=0, rdata=0, mem_* fields=0.
  - state=IDLE, counters=0.
- Reset mid-transaction abandons it; no valid is issued afterwards.
- Zero-wait transaction: cycle 0 ready, cycle 1 mem_request + acknowledge, cycle 2 valid.
  - Next grant can occur in cycle 2, giving peak throughput of one access per 2 cycles.
- mem_request is registered. It rises the cycle after grant and falls the cycle after acknowledge or timeout. mem_* fields are stable throughout.
- Timeout: mem_request is high for exactly TIMEOUT_CYCLES cycles; valid and bus_error follow in the next cycle.
- Acknowledge in the same cycle the counter hits the limit: the acknowledge wins, with a normal completion and no bus_error.
- Simultaneous requests in IDLE are resolved the same cycle; the loser keeps its request and sees ready no earlier than the loser's next IDLE cycle.

## Test plan
- Single fetch, address 0x100, acknowledge in cycle 1 with rdata 0x00500093:
  - expected: ready cycle 0, mem_request cycle 1 only, instr_valid cycle 2, instr_rdata=0x00500093.
- Store (0x200, wdata 0xDEADBEEF, size 10) with 3 wait cycles:
  - expected: mem_write=1 and fields stable for 4 cycles, one data_valid, data_rdata unchanged.
- Fetch and data both requesting continuously:
  - expected grant order with DATA_BURST_LIMIT=4: D, D, D, D, I, D, D, D, D, I...
- No acknowledge with TIMEOUT_CYCLES=15:
  - expected: mem_request high 15 cycles, then data_valid + bus_error one cycle, data_rdata=0, state IDLE.
- Acknowledge on the 15th busy cycle:
  - expected: normal completion, bus_error=0.
- rst_n asserted low during BUSY_DATA:
  - expected: mem_request=0 immediately, no data_valid after release, next request granted normally.
